// File: rtl/timer_bank_pkg.sv
// rtl/timer_bank_pkg.sv - shared types and default sizes for the timer bank
package timer_bank_pkg;

    // Per-channel timer state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int CHANNELS_DEF = 4;
    localparam int WIDTH_DEF    = 4;

endpackage

// File: rtl/timer_bank_if.sv
// rtl/timer_bank_if.sv - control/status bundle between the controller and the timer bank
//
// Signals (packing: channel i at [i*WIDTH +: WIDTH] for multi-bit fields)
//   oneHz_enable : shared single-cycle tick strobe
//   Value        : per-channel duration in ticks
//   start_timer  : per-channel start/restart strobe
//   stop_timer   : per-channel abort strobe
//   auto_reload  : per-channel mode, 1 = reload after expiry, 0 = one-shot
//   hold         : per-channel tick hold (only with TIMER_BANK_PAUSE_EN)
//   expired      : per-channel one-cycle expiry pulse
//   busy         : channel is in ARM or RUN
//   time_left    : per-channel current count
// Modports: master = controller side, slave = timer bank side.
// Optional macro: TIMER_BANK_PAUSE_EN adds hold.
interface timer_bank_if
    import timer_bank_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int WIDTH    = WIDTH_DEF
);

    logic                      oneHz_enable;
    logic [CHANNELS*WIDTH-1:0] Value;
    logic [CHANNELS-1:0]       start_timer;
    logic [CHANNELS-1:0]       stop_timer;
    logic [CHANNELS-1:0]       auto_reload;
`ifdef TIMER_BANK_PAUSE_EN
    logic [CHANNELS-1:0]       hold;
`endif
    logic [CHANNELS-1:0]       expired;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS*WIDTH-1:0] time_left;

    modport master (
        output oneHz_enable,
        output Value,
        output start_timer,
        output stop_timer,
        output auto_reload,
`ifdef TIMER_BANK_PAUSE_EN
        output hold,
`endif
        input  expired,
        input  busy,
        input  time_left
    );

    modport slave (
        input  oneHz_enable,
        input  Value,
        input  start_timer,
        input  stop_timer,
        input  auto_reload,
`ifdef TIMER_BANK_PAUSE_EN
        input  hold,
`endif
        output expired,
        output busy,
        output time_left
    );

endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one countdown timer channel: IDLE/ARM/RUN FSM plus counter
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   tick_i     : shared tick strobe
//   value_i    : duration in ticks (sampled in ARM and on auto-reload)
//   start_i    : start/restart strobe
//   stop_i     : abort strobe, beats start
//   reload_i   : 1 = auto-reload after expiry, 0 = one-shot
//   hold_i     : ignore ticks while in RUN (only with TIMER_BANK_PAUSE_EN)
//   expired_o  : registered one-cycle expiry pulse
//   busy_o     : channel is in ARM or RUN
//   count_o    : current count
// Optional macro: TIMER_BANK_PAUSE_EN adds hold_i.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             reload_i,
`ifdef TIMER_BANK_PAUSE_EN
    input  logic             hold_i,
`endif
    output logic             expired_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] count_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             expired_q, expired_d;
    logic             tick_run;

    // The count holds "ticks remaining minus one": expiry fires on the tick
    // that finds zero, so a duration of V expires on the V-th tick. V = 0
    // saturates to the same load as V = 1.
    function automatic logic [WIDTH-1:0] load_value(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - WIDTH'(1);
    endfunction

`ifdef TIMER_BANK_PAUSE_EN
    assign tick_run = tick_i & ~hold_i;
`else
    assign tick_run = tick_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;

        if (stop_i) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start_i) begin
            // Restart from any state; an expiry tick in the same cycle is
            // swallowed because the tick branch below is not reached.
            state_d = ARM;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                ARM: begin
                    // Value is valid one cycle after start; ticks here are dropped.
                    count_d = load_value(value_i);
                    state_d = RUN;
                end
                RUN: begin
                    if (tick_run) begin
                        if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            expired_d = 1'b1;
                            if (reload_i) begin
                                count_d = load_value(value_i);
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign expired_o = expired_q;
    assign busy_o    = (state_q != IDLE);
    assign count_o   = count_q;

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel countdown timer bank sharing a 1 Hz tick
//
// Ports
//   clk        : system clock
//   Reset_Sync : asynchronous active-high reset
//   bus        : timer_bank_if.slave (tick, durations, start/stop/mode in;
//                expired, busy, time_left out)
// Parameters: CHANNELS (1..16) independent channels of WIDTH-bit counters.
// Optional macro: TIMER_BANK_PAUSE_EN routes per-channel hold into each channel.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int WIDTH    = WIDTH_DEF
) (
    input  logic         clk,
    input  logic         Reset_Sync,
    timer_bank_if.slave  bus
);

    logic [CHANNELS-1:0]       expired_w;
    logic [CHANNELS-1:0]       busy_w;
    logic [CHANNELS*WIDTH-1:0] count_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk       (clk),
            .rst       (Reset_Sync),
            .tick_i    (bus.oneHz_enable),
            .value_i   (bus.Value[i*WIDTH +: WIDTH]),
            .start_i   (bus.start_timer[i]),
            .stop_i    (bus.stop_timer[i]),
            .reload_i  (bus.auto_reload[i]),
`ifdef TIMER_BANK_PAUSE_EN
            .hold_i    (bus.hold[i]),
`endif
            .expired_o (expired_w[i]),
            .busy_o    (busy_w[i]),
            .count_o   (count_w[i*WIDTH +: WIDTH])
        );
    end

    assign bus.expired   = expired_w;
    assign bus.busy      = busy_w;
    assign bus.time_left = count_w;

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - scoreboard bench for timer_bank
module tb_timer_bank;
    import timer_bank_pkg::*;

    localparam int CH = 4;
    localparam int W  = 4;

    typedef struct {
        logic [CH-1:0] mask;
        int            tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk        (clk),
        .Reset_Sync (rst),
        .bus        (bus.slave)
    );

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   tick_no   = 0;
    exp_t sb[$];
    exp_t cur;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int tl(input int ch);
        logic [CH*W-1:0] v;
        v = bus.time_left;
        return int'(v[ch*W +: W]);
    endfunction

    // Monitor: every expiry pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (!rst && bus.expired != '0) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_expiry: got mask %b expected none (tick %0d)",
                         bus.expired, tick_no);
            end else begin
                cur = sb.pop_front();
                check("expiry_mask", int'(bus.expired), int'(cur.mask));
                check("expiry_tick", tick_no, cur.tick);
                // one-shot channels leave RUN in the same cycle they pulse
                check("busy_at_expiry", int'(bus.busy & bus.expired),
                      int'(bus.expired & bus.auto_reload));
            end
        end
    end

    // One tick, then idle so ticks are 10 clocks apart
    task automatic tick(input logic [CH-1:0] exp_mask);
        @(negedge clk);
        bus.oneHz_enable = 1'b1;
        tick_no++;
        if (exp_mask != '0) sb.push_back('{exp_mask, tick_no});
        @(negedge clk);
        bus.oneHz_enable = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic start(input logic [CH-1:0] m);
        @(negedge clk);
        bus.start_timer = m;
        @(negedge clk);
        bus.start_timer = '0;
    endtask

    task automatic set_value(input int ch, input int v);
        bus.Value[ch*W +: W] = W'(v);
    endtask

    initial begin
        rst              = 1'b1;
        bus.oneHz_enable = 1'b0;
        bus.Value        = '0;
        bus.start_timer  = '0;
        bus.stop_timer   = '0;
        bus.auto_reload  = '0;
`ifdef TIMER_BANK_PAUSE_EN
        bus.hold         = '0;
`endif
        repeat (3) @(negedge clk);
        check("reset_time_left", int'(bus.time_left), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_expired", int'(bus.expired), 0);
        rst = 1'b0;

        // ch0 V=3 one-shot, ch1 V=0 expires on first tick
        set_value(0, 3);
        set_value(1, 0);
        start(4'b0011);
        @(negedge clk);
        check("ch0_busy_run", int'(bus.busy[0]), 1);
        check("ch0_load", tl(0), 2);
        tick(4'b0010);
        check("ch0_after_t1", tl(0), 1);
        check("ch1_idle_after_expiry", int'(bus.busy[1]), 0);
        tick(4'b0000);
        check("ch0_after_t2", tl(0), 0);
        check("ch0_busy_t2", int'(bus.busy[0]), 1);
        tick(4'b0001);
        check("ch0_idle_after_expiry", int'(bus.busy[0]), 0);
        check("ch0_count_zero", tl(0), 0);

        // ch2 auto-reload V=2, seven ticks
        bus.auto_reload[2] = 1'b1;
        set_value(2, 2);
        start(4'b0100);
        for (int t = 1; t <= 7; t++) tick((t % 2 == 0) ? 4'b0100 : 4'b0000);
        check("ch2_busy_reload", int'(bus.busy[2]), 1);
        check("ch2_count", tl(2), 0);
        @(negedge clk);
        bus.stop_timer = 4'b0100;
        @(negedge clk);
        bus.stop_timer = '0;
        bus.auto_reload[2] = 1'b0;
        check("ch2_stopped_busy", int'(bus.busy[2]), 0);

        // ch3 restart mid-count
        set_value(3, 5);
        start(4'b1000);
        tick(4'b0000);
        tick(4'b0000);
        check("ch3_mid", tl(3), 2);
        start(4'b1000);
        @(negedge clk);
        check("ch3_reloaded", tl(3), 4);
        for (int t = 1; t <= 5; t++) tick((t == 5) ? 4'b1000 : 4'b0000);
        // stop together with start: stop wins
        start(4'b1000);
        @(negedge clk);
        bus.stop_timer  = 4'b1000;
        bus.start_timer = 4'b1000;
        @(negedge clk);
        bus.stop_timer  = '0;
        bus.start_timer = '0;
        check("ch3_stop_wins_busy", int'(bus.busy[3]), 0);
        check("ch3_stop_wins_count", tl(3), 0);
        tick(4'b0000);

        // tick and start coincide at count 0: no pulse, re-arm
        set_value(0, 2);
        start(4'b0001);
        tick(4'b0000);
        check("ch0_at_zero", tl(0), 0);
        @(negedge clk);
        bus.oneHz_enable = 1'b1;
        bus.start_timer  = 4'b0001;
        tick_no++;
        @(negedge clk);
        bus.oneHz_enable = 1'b0;
        bus.start_timer  = '0;
        check("ch0_rearm_busy", int'(bus.busy[0]), 1);
        @(negedge clk);
        check("ch0_rearm_load", tl(0), 1);
        // tick during ARM is ignored
        @(negedge clk);
        bus.start_timer = 4'b0001;
        @(negedge clk);
        bus.start_timer  = '0;
        bus.oneHz_enable = 1'b1;
        tick_no++;
        @(negedge clk);
        bus.oneHz_enable = 1'b0;
        check("ch0_arm_tick_ignored", tl(0), 1);
        tick(4'b0000);
        tick(4'b0001);

        // asynchronous reset while all channels run
        set_value(0, 5); set_value(1, 5); set_value(2, 5); set_value(3, 5);
        start(4'b1111);
        tick(4'b0000);
        check("all_running", int'(bus.busy), 15);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_time_left", int'(bus.time_left), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_expired", int'(bus.expired), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 6; t++) tick(4'b0000);
        check("post_rst_idle", int'(bus.busy), 0);
        set_value(0, 1);
        start(4'b0001);
        tick(4'b0001);

`ifdef TIMER_BANK_PAUSE_EN
        set_value(0, 4);
        start(4'b0001);
        tick(4'b0000);
        check("hold_before", tl(0), 2);
        bus.hold[0] = 1'b1;
        for (int t = 0; t < 3; t++) tick(4'b0000);
        check("hold_frozen", tl(0), 2);
        bus.hold[0] = 1'b0;
        tick(4'b0000);
        tick(4'b0000);
        tick(4'b0001);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
